mux_n_rr: RTL
=============

Name: mux_n_rr

Overview:
- Parametrised, registered N-to-1 multiplexer of W-bit channels with valid/ready handshaking on every input and on the output.
- Successor to the 2:1 and 4-bit 2:1 registered muxes.
- Adds configurable channel count and width, round-robin arbitration between valid channels, and a manual-select mode equivalent to the legacy S-driven mux.
- Sits between the per-channel producers and the single downstream consumer in the gate-tester datapath.

Parameters:
- N, 4, number of input channels (2..16).
- W, 4, data width per channel.
- SW, 2, select/pointer width; must equal clog2(N).

Ports:
- clk  input  1  rising-edge clock.
- Reset_L  input  1  asynchronous, active-low reset.
- Mode  input  1  0 = round-robin arbitration; 1 = manual select by S.
- S  input  SW  manual channel select, used only when Mode=1.
- In_Data  input  N*W  channel i occupies bits [i*W+W-1 : i*W].
- In_Valid  input  N  per-channel valid.
- In_Ready  output  N  per-channel ready (combinational).
- Out_Data  output  W  registered selected data.
- Out_Sel  output  SW  registered index of the channel that produced Out_Data.
- Out_Valid  output  1  registered output valid.
- Out_Ready  input  1  downstream ready.

Behaviour:
- Reset: Reset_L low clears Out_Valid=0, Out_Data=0, Out_Sel=0 and the RR pointer ptr=0 immediately, without waiting for clk. In_Ready=0 while Reset_L is low.
  - Reset asserted mid-transfer drops any held word; no partial state survives.
- Load condition: load = ~Out_Valid | Out_Ready. The output register accepts a new word only when load=1.
- Grant, Mode=0:
  - Scan channels ptr, ptr+1, ..., ptr+N-1, all mod N.
  - The first channel with In_Valid=1 is granted.
  - No valid channel means no grant.
- Grant, Mode=1:
  - Grant = S if S<N and In_Valid[S]=1; otherwise no grant.
  - S>=N never grants.
- Handshake:
  - In_Ready[g]=load for the granted channel g; all other In_Ready bits are 0.
  - Transfer occurs when In_Valid[g] & In_Ready[g].
  - In_Ready never depends on In_Valid of a non-granted channel.
- Transfer on rising clk:
  - Out_Data <= channel g data; Out_Sel <= g; Out_Valid <= 1; ptr <= (g+1) mod N.
  - ptr is updated in both modes, so switching modes resumes fairly.
- Drain without refill: load=1 and no grant → Out_Valid <= 0. Out_Data and Out_Sel then follow the Optional Feature rules.
- Stall: Out_Valid=1 and Out_Ready=0 → Out_Data, Out_Sel and ptr hold; all In_Ready=0.
- Latency and throughput:
  - Latency is 1 cycle from input transfer to Out_Valid.
  - Throughput is 1 word per cycle when Out_Ready stays high (simultaneous drain and refill in the same cycle).
- Fairness: in Mode=0 with all channels continuously valid and no stall, grants cycle 0,1,...,N-1,0 with no repeats.
- ptr wraps from N-1 to 0.
- Mode and S are sampled combinationally each cycle; a change takes effect in the same cycle's grant.
- Out_Data is W bits with no width conversion; In_Data bits are never mixed across channels.

Optional Feature:
- Macro: MUX_HOLD_LAST_EN.
- Defined: when Out_Valid drops, Out_Data and Out_Sel keep the last transferred values (legacy-mux "hold" behaviour).
- Undefined: whenever Out_Valid is 0 after a drain, Out_Data is forced to 0 and Out_Sel to 0 on the same clock edge.
- Handshake timing and arbitration are identical in both builds.

Test Plan:
- Reset: drive Reset_L=0 asynchronously mid-cycle with Out_Valid=1 → Out_Valid=0, Out_Data=0, Out_Sel=0 before the next clk edge. After release, a Mode=0 grant starts at channel 0.
- Round-robin, N=4, W=4, Mode=0:
  - Setup: all In_Valid=1, data ch0..3=4'h1,4'h2,4'h3,4'h4, Out_Ready=1.
  - Required: Out_Sel sequence 0,1,2,3,0; Out_Data 1,2,3,4,1; Out_Valid=1 from the 2nd cycle on.
- Skip and wrap: In_Valid=4'b1001, ptr=1 → grant ch3; next cycle grant ch0; next cycle grant ch3.
- Manual mode: Mode=1, S=2, In_Valid=4'b0100, ch2=4'hA → Out_Data=4'hA, Out_Sel=2. Then S=2 with In_Valid[2]=0 → no grant, In_Ready=0, Out_Valid drops.
- Stall:
  - Stimulus: Out_Ready=0 for 3 cycles with Out_Valid=1, Out_Data=4'h5.
  - Required: Out_Data stays 4'h5, all In_Ready=0, ptr unchanged.
  - Then Out_Ready=1 → same-cycle refill; no bubble, no lost word.
- Drain: all In_Valid=0 after a word 4'hC is consumed → Out_Valid=0. With MUX_HOLD_LAST_EN, Out_Data stays 4'hC; without it, Out_Data=0.

Source files
------------

// File: rtl/mux_n_rr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_n_rr: registered N:1 valid/ready mux, round-robin or manual (S) select.
// Option macro MUX_HOLD_LAST_EN: keep last Out_Data/Out_Sel when drained. Rev 1.0
// ---------------------------------------------------------------------------
module mux_n_rr #(
  parameter int N  = 4,
  parameter int W  = 4,
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          Reset_L,
  input  logic          Mode,
  input  logic [SW-1:0] S,
  input  logic [N*W-1:0] In_Data,
  input  logic [N-1:0]  In_Valid,
  output logic [N-1:0]  In_Ready,
  output logic [W-1:0]  Out_Data,
  output logic [SW-1:0] Out_Sel,
  output logic          Out_Valid,
  input  logic          Out_Ready
);

  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          valid_q, valid_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          w_load;
  logic          w_gnt_vld;
  logic [SW-1:0] w_gnt_idx;
  logic [W-1:0]  w_gnt_data;
  logic [SW:0]   w_scan;

  assign w_load = ~valid_q | Out_Ready;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    if (Mode) begin
      if (({1'b0, S} < (SW+1)'(N)) && In_Valid[S]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = S;
      end
    end else begin
      for (int k = N-1; k >= 0; k--) begin
        w_scan = {1'b0, ptr_q} + (SW+1)'(k);
        if (w_scan >= (SW+1)'(N)) begin
          w_scan = w_scan - (SW+1)'(N);
        end
        if (In_Valid[w_scan[SW-1:0]]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = w_scan[SW-1:0];
        end
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    for (int c = 0; c < N; c++) begin
      if (SW'(c) == w_gnt_idx) begin
        w_gnt_data = In_Data[c*W +: W];
      end
    end
  end

  always_comb begin
    In_Ready = '0;
    if (Reset_L && w_gnt_vld && w_load) begin
      In_Ready[w_gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (w_load) begin
      if (w_gnt_vld) begin
        valid_d = 1'b1;
        data_d  = w_gnt_data;
        sel_d   = w_gnt_idx;
        ptr_d   = (w_gnt_idx == SW'(N-1)) ? '0 : w_gnt_idx + SW'(1);
      end else begin
        valid_d = 1'b0;
`ifdef MUX_HOLD_LAST_EN
        data_d  = data_q;
        sel_d   = sel_q;
`else
        data_d  = '0;
        sel_d   = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge Reset_L) begin
    if (!Reset_L) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign Out_Data  = data_q;
  assign Out_Sel   = sel_q;
  assign Out_Valid = valid_q;

endmodule
`default_nettype wire
